// File: rtl/step_sequencer.sv
// ============================================================================
// Module  : step_sequencer
// Purpose : Programmable STEPS-entry note loop driving the voice trigger and
//           oscillator period at a tempo-tick rate.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_sequencer #(
  parameter int STEPS    = 8,
  parameter int TICK_DIV = 20480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [7:0]               tempo,
  input  logic [7:0]               gate_len,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [11:0]              wr_count,
  input  logic                     wr_rest,
  output logic                     trig,
  output logic [11:0]              osc_count,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     step_strobe,
  output logic                     busy
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] c_pre_last = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] c_pre_one  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  state_t         r_state;
  logic [11:0]    r_count [STEPS];
  logic           r_rest  [STEPS];
  logic [PW-1:0]  r_pre;
  logic [7:0]     r_tick;
  logic [7:0]     r_tlim;
  logic [7:0]     r_gate;
  logic           r_rest_cur;

  logic           w_pre_wrap;
  logic           w_step_end;
  logic [PW-1:0]  w_pre_n;
  logic [7:0]     w_tick_n;
  logic           w_gate_on;

  // Position of the next cycle within the step, tracked as (tick, prescaler)
  // so the gate compare against gate_len*TICK_DIV needs no multiplier.
  assign w_pre_wrap = (r_pre == c_pre_last);
  assign w_step_end = w_pre_wrap && (r_tick == (r_tlim - 8'd1));
  assign w_pre_n    = w_pre_wrap ? '0 : (r_pre + c_pre_one);
  assign w_tick_n   = w_pre_wrap ? (r_tick + 8'd1) : r_tick;
  assign w_gate_on  = (w_tick_n < r_gate) ||
                      ((w_tick_n == r_gate) && (w_pre_n == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        r_count[i] <= '0;
        r_rest[i]  <= 1'b1;
      end
    end else if (wr_en) begin
      r_count[wr_addr] <= wr_count;
      r_rest[wr_addr]  <= wr_rest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      trig        <= 1'b0;
      osc_count   <= '0;
      step        <= '0;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
      r_pre       <= '0;
      r_tick      <= '0;
      r_tlim      <= 8'd1;
      r_gate      <= '0;
      r_rest_cur  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          trig   <= 1'b0;
          step   <= '0;
          r_pre  <= '0;
          r_tick <= '0;
          if (run) begin
            r_state     <= S_LOAD;
            step_strobe <= 1'b1;
            busy        <= 1'b1;
          end else begin
            step_strobe <= 1'b0;
            busy        <= 1'b0;
          end
        end

        S_LOAD: begin
          if (!run) begin
            r_state     <= S_IDLE;
            trig        <= 1'b0;
            step        <= '0;
            step_strobe <= 1'b0;
            busy        <= 1'b0;
          end else begin
            r_state     <= S_PLAY;
            step_strobe <= 1'b0;
            r_tlim      <= (tempo == 8'd0) ? 8'd1 : tempo;
            r_gate      <= gate_len;
            r_rest_cur  <= r_rest[step];
            if (!r_rest[step]) begin
              osc_count <= r_count[step];
            end
            // LOAD is c=0, so the next cycle is c=1 (tick 0, prescaler 1).
            r_pre       <= c_pre_one;
            r_tick      <= '0;
            trig        <= !r_rest[step] && (gate_len != 8'd0);
          end
        end

        S_PLAY: begin
          if (!run) begin
            r_state     <= S_IDLE;
            trig        <= 1'b0;
            step        <= '0;
            step_strobe <= 1'b0;
            busy        <= 1'b0;
          end else if (w_step_end) begin
            r_state     <= S_LOAD;
            trig        <= 1'b0;
            step        <= step + 1'b1;
            step_strobe <= 1'b1;
            r_pre       <= '0;
            r_tick      <= '0;
          end else begin
            r_pre  <= w_pre_n;
            r_tick <= w_tick_n;
            trig   <= !r_rest_cur && w_gate_on;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          trig        <= 1'b0;
          step        <= '0;
          step_strobe <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
